// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits,
// odd parity and stop, then device ACK and bus-idle wait.
module ps2_host_tx #(
  parameter int CLK_INHIBIT = 3000,
  parameter int DATA_SETUP  = 25,
  parameter int TIMEOUT     = 375000,
  parameter int CNT_W       = 19
) (
  input  logic       clk25,
  input  logic       reset_in,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(CLK_INHIBIT - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST =
    CNT_W'(DATA_SETUP - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [9:0]       frame;
  logic [9:0]       frame_nxt;
  logic [3:0]       idx;
  logic [3:0]       idx_nxt;
  logic             bit_oe;
  logic             bit_oe_nxt;
  logic             done_nxt;
  logic             err_nxt;

  logic clk_s1;
  logic clk_s2;
  logic clk_prev;
  logic data_s1;
  logic data_s2;
  logic fe;

  // Idle bus level is high, so the synchronizers reset to 1.
  always_ff @(posedge clk25) begin
    if (reset_in) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_i;
      data_s2  <= data_s1;
    end
  end

  assign fe = clk_prev & ~clk_s2;

  always_ff @(posedge clk25) begin
    if (reset_in) begin
      state  <= S_IDLE;
      cnt    <= '0;
      frame  <= '0;
      idx    <= '0;
      bit_oe <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      frame  <= frame_nxt;
      idx    <= idx_nxt;
      bit_oe <= bit_oe_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    frame_nxt  = frame;
    idx_nxt    = idx;
    bit_oe_nxt = bit_oe;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tx_start) begin
          frame_nxt = {1'b1, ~^tx_data, tx_data};
          cnt_nxt   = '0;
          state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_START;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_START: begin
        if (cnt == SETUP_LAST) begin
          cnt_nxt    = '0;
          idx_nxt    = '0;
          bit_oe_nxt = 1'b1;
          state_nxt  = S_BITS;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_BITS: begin
        // frame shifts right so bit 0 is always the next to send
        if (fe) begin
          bit_oe_nxt = ~frame[0];
          frame_nxt  = {1'b0, frame[9:1]};
          idx_nxt    = idx + 4'd1;
          cnt_nxt    = '0;
          if (idx == 4'd9) begin
            state_nxt = S_ACK;
          end
        end else if (cnt == TO_LAST) begin
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (fe) begin
          cnt_nxt = '0;
          if (!data_s2) begin
            state_nxt = S_WAIT_IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (cnt == TO_LAST) begin
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == TO_LAST) begin
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) ||
                       (state == S_START);
  assign ps2_data_oe = (state == S_START) ||
                       ((state == S_BITS) && bit_oe);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural
// PS/2 device that clocks the frame in and ACKs it.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk25 = 1'b0;
  logic       reset_in = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int starts = 0;
  logic busy_q = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_INHIBIT(100),
    .DATA_SETUP (5),
    .TIMEOUT    (2000),
    .CNT_W      (19)
  ) dut (
    .clk25      (clk25),
    .reset_in   (reset_in),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk25 = ~clk25;

  always @(negedge clk25) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (busy && !busy_q) starts++;
    busy_q = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // Reference frame as the device should see it on the wire.
  function automatic logic [9:0] exp_frame(input int b);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((b >> i) % 2) != 0;
      ones += (b >> i) % 2;
    end
    f[8] = (ones % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic launch(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk25);
    tx_start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk25);
      k++;
    end while (!done && !err && k < 500);
  endtask

  // mode 0 = ACK, 1 = NACK, 2 = never clock
  task automatic dev_xfer(
    input  int         mode,
    input  int         hold,
    input  int         abort_edge,
    output int         inh,
    output int         setup,
    output logic [9:0] bits,
    output bit         started
  );
    int guard;
    guard = 0;
    inh = 0;
    setup = 0;
    bits = '0;
    started = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)
           && guard < 1000) begin
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      if (ps2_clk_oe && ps2_data_oe) setup++;
      guard++;
      @(negedge clk25);
    end
    if (guard >= 1000) return;
    started = 1;
    if (mode == 2) return;
    for (int i = 0; i < 10; i++) begin
      repeat (HALF) @(negedge clk25);
      dev_clk_low = 1'b1;
      if (i + 1 == abort_edge) return;
      repeat (HALF) @(negedge clk25);
      bits[i] = ps2_data_i;
      dev_clk_low = 1'b0;
    end
    repeat (HALF / 2) @(negedge clk25);
    if (mode == 0) dev_data_low = 1'b1;
    repeat (HALF / 2) @(negedge clk25);
    dev_clk_low = 1'b1;
    repeat (hold) @(negedge clk25);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset;
    reset_in = 1'b1;
    repeat (3) @(negedge clk25);
    reset_in = 1'b0;
    @(negedge clk25);
    n_tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000",
        {ps2_clk_oe, ps2_data_oe, busy, done, err});
    end
  endtask

  task automatic test_ed;
    int inh, setup, k, d0, e0;
    logic [9:0] bits;
    bit st;
    d0 = done_cnt;
    e0 = err_cnt;
    launch(8'hED);
    dev_xfer(0, HALF, 0, inh, setup, bits, st);
    wait_done(k);
    n_tests++;
    if (inh !== 100) begin
      n_fail++;
      $display("FAIL ed_inhibit: got %0d want 100", inh);
    end
    n_tests++;
    if (setup !== 5) begin
      n_fail++;
      $display("FAIL ed_setup: got %0d want 5", setup);
    end
    n_tests++;
    if (bits !== exp_frame(8'hED)) begin
      n_fail++;
      $display("FAIL ed_bits: got %b want %b",
        bits, exp_frame(8'hED));
    end
    n_tests++;
    if (k !== 3 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL ed_done: k=%0d busy=%b err=%b want 3 0 0",
        k, busy, err);
    end
    repeat (5) @(negedge clk25);
    n_tests++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL ed_pulses: done=%0d err=%0d want 1 0",
        done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_zero_ignore_start;
    int inh, setup, k, d0, s0;
    logic [9:0] bits;
    bit st;
    d0 = done_cnt;
    s0 = starts;
    launch(8'h00);
    fork
      dev_xfer(0, HALF, 0, inh, setup, bits, st);
      begin
        repeat (300) @(negedge clk25);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk25);
        tx_start = 1'b0;
        tx_data  = 8'h00;
      end
    join
    wait_done(k);
    n_tests++;
    if (bits !== exp_frame(0) || bits[8] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_bits: got %b want %b",
        bits, exp_frame(0));
    end
    repeat (300) @(negedge clk25);
    n_tests++;
    if (starts - s0 !== 1 || done_cnt - d0 !== 1
        || ps2_clk_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_frames: starts=%0d done=%0d want 1 1",
        starts - s0, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int inh, setup, k, d0, e0;
    logic [9:0] bits;
    bit st;
    logic [7:0] b;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      launch(b);
      dev_xfer(0, HALF, 0, inh, setup, bits, st);
      wait_done(k);
      n_tests++;
      if (bits !== exp_frame(b) || done !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_%0d: byte=%h got %b done=%b want %b",
          n, b, bits, done, exp_frame(b));
      end
    end
    repeat (5) @(negedge clk25);
    n_tests++;
    if (done_cnt - d0 !== 4 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: done=%0d err=%0d want 4 0",
        done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_timeout;
    int inh, setup, k, d0, e0;
    logic [9:0] bits;
    bit st;
    d0 = done_cnt;
    e0 = err_cnt;
    launch(8'($urandom_range(0, 255)));
    dev_xfer(2, HALF, 0, inh, setup, bits, st);
    k = 0;
    while (!err && k < 3000) begin
      @(negedge clk25);
      k++;
    end
    n_tests++;
    if (!st || k !== 2000) begin
      n_fail++;
      $display("FAIL timeout_delay: got %0d want 2000", k);
    end
    n_tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_lines: got %b want 000",
        {ps2_clk_oe, ps2_data_oe, busy});
    end
    repeat (5) @(negedge clk25);
    n_tests++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL timeout_pulses: done=%0d err=%0d want 0 1",
        done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_nack;
    int inh, setup, d0, e0;
    logic [9:0] bits;
    bit st;
    logic [7:0] b;
    d0 = done_cnt;
    e0 = err_cnt;
    b = 8'($urandom_range(0, 255));
    launch(b);
    dev_xfer(1, HALF, 0, inh, setup, bits, st);
    repeat (10) @(negedge clk25);
    n_tests++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1
        || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nack: done=%0d err=%0d busy=%b want 0 1 0",
        done_cnt - d0, err_cnt - e0, busy);
    end
  endtask

  task automatic test_reset_mid;
    int inh, setup, k, d0, e0;
    logic [9:0] bits;
    bit st;
    d0 = done_cnt;
    e0 = err_cnt;
    launch(8'($urandom_range(0, 255)));
    dev_xfer(0, HALF, 5, inh, setup, bits, st);
    reset_in = 1'b1;
    @(negedge clk25);
    reset_in = 1'b0;
    n_tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_lines: got %b want 000",
        {ps2_clk_oe, ps2_data_oe, busy});
    end
    dev_clk_low = 1'b0;
    repeat (200) @(negedge clk25);
    n_tests++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_pulses: done=%0d err=%0d want 0 0",
        done_cnt - d0, err_cnt - e0);
    end
    launch(8'hFF);
    dev_xfer(0, HALF, 0, inh, setup, bits, st);
    wait_done(k);
    n_tests++;
    if (bits !== exp_frame(8'hFF) || done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ff: got %b done=%b want %b",
        bits, done, exp_frame(8'hFF));
    end
  endtask

  task automatic test_hold_clock;
    int inh, setup, k;
    logic [9:0] bits;
    bit st;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    launch(b);
    dev_xfer(0, 50, 0, inh, setup, bits, st);
    wait_done(k);
    n_tests++;
    if (k !== 3 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_done: k=%0d done=%b want 3 1", k, done);
    end
    n_tests++;
    if (bits !== exp_frame(b)) begin
      n_fail++;
      $display("FAIL hold_bits: got %b want %b",
        bits, exp_frame(b));
    end
  endtask

  initial begin
    @(negedge clk25);
    test_reset();
    test_ed();
    test_zero_ignore_start();
    test_back_to_back();
    test_timeout();
    test_nack();
    test_reset_mid();
    test_hold_clock();
    repeat (10) @(negedge clk25);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
